// File: rtl/adc_sample_fifo_if.sv
// Handshake/status bundle between the ADC capture side (master) and the sample FIFO (slave).
//  master drives: wr_en, wr_ch, wr_data, rd_en, clr_flags
//  slave drives : rd_data, rd_ch, rd_valid, count, full, empty,
//                 almost_full, almost_empty, overflow, underflow
interface adc_sample_fifo_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DEPTH      = 16384
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic                  clr_flags;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CH_W-1:0]       rd_ch;
    logic                  rd_valid;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, clr_flags,
        input  rd_data, rd_ch, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, clr_flags,
        output rd_data, rd_ch, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/adc_sample_fifo.sv
// Multi-channel ADC sample FIFO: stores {channel, sample} entries between the ADS8528
// capture front end and the SPI readout. Registered read with valid strobe, full-depth
// occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags.
//  clk  : clock
//  rst  : synchronous, active-low reset
//  bus  : adc_sample_fifo_if.slave (write/read requests, read data, status, error flags)
module adc_sample_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16384,
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - 16,
    parameter int unsigned AE_LEVEL   = 16
) (
    input  logic               clk,
    input  logic               rst,
    adc_sample_fifo_if.slave   bus
);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = CH_W + DATA_WIDTH;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CH_W-1:0]       rd_ch_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full_c;
    logic empty_c;
    logic wr_acc_c;
    logic rd_acc_c;
    logic wr_rej_c;
    logic rd_rej_c;

    // Status decode and acceptance, all from the registered (pre-edge) count
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        wr_acc_c = bus.wr_en & ~full_c;
        rd_acc_c = bus.rd_en & ~empty_c;
        wr_rej_c = bus.wr_en & full_c;
        rd_rej_c = bus.rd_en & empty_c;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sample storage; not cleared by reset, but reset blocks writes
    always_ff @(posedge clk) begin
        if (rst && wr_acc_c) begin
            mem[wr_ptr] <= {bus.wr_ch, bus.wr_data};
        end
    end

    // Registered read port; data holds when no read is accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc_c;
            if (rd_acc_c) begin
                {rd_ch_q, rd_data_q} <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags; a new rejection beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_rej_c)           overflow_q  <= 1'b1;
            else if (bus.clr_flags) overflow_q  <= 1'b0;
            if (rd_rej_c)           underflow_q <= 1'b1;
            else if (bus.clr_flags) underflow_q <= 1'b0;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_ch        = rd_ch_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// Self-checking bench for adc_sample_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_adc_sample_fifo;
    localparam int unsigned DW       = 16;
    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned DEPTH    = 128;
    localparam int unsigned AF_LEVEL = DEPTH - 16;
    localparam int unsigned AE_LEVEL = 16;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned ENTRY_W  = CH_W + DW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    adc_sample_fifo_if #(.DATA_WIDTH(DW), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

    adc_sample_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
        .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [ENTRY_W-1:0] q[$];
    logic [ENTRY_W-1:0] exp_entry;
    logic               exp_valid;
    logic               exp_ovf;
    logic               exp_unf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",        32'(bus.count),        32'(q.size()));
        chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
        chk("empty",        32'(bus.empty),        32'(q.size() == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF_LEVEL));
        chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE_LEVEL));
        chk("rd_valid",     32'(bus.rd_valid),     32'(exp_valid));
        chk("rd_data",      32'(bus.rd_data),      32'(exp_entry[DW-1:0]));
        chk("rd_ch",        32'(bus.rd_ch),        32'(exp_entry[ENTRY_W-1:DW]));
        chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
        chk("underflow",    32'(bus.underflow),    32'(exp_unf));
    endtask

    // One clock: drive requests, advance model on the edge, check just after it
    task automatic step(input logic wr, input logic [CH_W-1:0] ch, input logic [DW-1:0] d,
                        input logic rd, input logic clr);
        logic was_full;
        logic was_empty;
        bus.wr_en     = wr;
        bus.wr_ch     = ch;
        bus.wr_data   = d;
        bus.rd_en     = rd;
        bus.clr_flags = clr;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        exp_valid = rd && !was_empty;
        if (rd && !was_empty) exp_entry = q.pop_front();
        if (wr && !was_full)  q.push_back({ch, d});
        if (wr && was_full)   exp_ovf = 1'b1;
        else if (clr)         exp_ovf = 1'b0;
        if (rd && was_empty)  exp_unf = 1'b1;
        else if (clr)         exp_unf = 1'b0;
        #1;
        check_all();
    endtask

    // Reset with both requests asserted to show reset overrides them
    task automatic do_reset();
        rst           = 1'b0;
        bus.wr_en     = 1'b1;
        bus.rd_en     = 1'b1;
        bus.wr_ch     = 3'd5;
        bus.wr_data   = 16'hdead;
        bus.clr_flags = 1'b0;
        @(posedge clk);
        q.delete();
        exp_entry = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        #1;
        check_all();
        rst = 1'b1;
    endtask

    task automatic wr_rand();
        step(1'b1, CH_W'($urandom_range(NUM_CH - 1)), DW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic rd_one();
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] pat;
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.clr_flags = 1'b0;
        exp_entry = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;

        // 1: reset then idle
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // 2: three tagged samples in, three out in order
        step(1'b1, 3'd0, 16'h0101, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'h0202, 1'b0, 1'b0);
        step(1'b1, 3'd2, 16'h0303, 1'b0, 1'b0);
        rd_one(); chk("t2_first",  32'(bus.rd_data), 32'h0101);
        rd_one(); chk("t2_second", 32'(bus.rd_data), 32'h0202);
        rd_one(); chk("t2_third",  32'(bus.rd_data), 32'h0303);
        chk("t2_ch", 32'(bus.rd_ch), 32'd2);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // 3: fill, overflow on extra write, clear flag
        for (int i = 0; i < DEPTH; i++) wr_rand();
        chk("t3_full",  32'(bus.full),  32'd1);
        chk("t3_count", 32'(bus.count), 32'(DEPTH));
        step(1'b1, 3'd7, 16'hbeef, 1'b0, 1'b0);
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t3_clr", 32'(bus.overflow), 32'd0);

        // 4: simultaneous access at full and at count 5
        step(1'b1, 3'd3, 16'h1234, 1'b1, 1'b0);
        chk("t4_full_cnt", 32'(bus.count), 32'(DEPTH - 1));
        chk("t4_full_ovf", 32'(bus.overflow), 32'd1);
        while (q.size() > 5) rd_one();
        step(1'b1, 3'd4, 16'h5678, 1'b1, 1'b0);
        chk("t4_cnt5", 32'(bus.count), 32'd5);
        chk("t4_rdv",  32'(bus.rd_valid), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // 5: streaming pairs across several pointer wraps
        pat = '0;
        for (int i = 0; i < 3 * DEPTH + 7; i++) begin
            step(1'b1, CH_W'(i), pat, 1'b1, 1'b0);
            pat = pat + DW'(1);
        end
        while (q.size() > 0) rd_one();

        // 6: underflow, mid-stream reset at 100, almost_full threshold
        rd_one();
        chk("t6_unf",  32'(bus.underflow), 32'd1);
        chk("t6_rdv",  32'(bus.rd_valid),  32'd0);
        for (int i = 0; i < 100; i++) wr_rand();
        chk("t6_c100", 32'(bus.count), 32'd100);
        do_reset();
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
        while (q.size() < AF_LEVEL - 1) wr_rand();
        chk("t6_af_below", 32'(bus.almost_full), 32'd0);
        wr_rand();
        chk("t6_af_at", 32'(bus.almost_full), 32'd1);

        // Random traffic with shifting write/read bias
        for (int seg = 0; seg < 6; seg++) begin
            int p_wr;
            p_wr = (seg % 3 == 0) ? 85 : (seg % 3 == 1) ? 15 : 50;
            for (int i = 0; i < 500; i++) begin
                step(logic'($urandom_range(99) < p_wr), CH_W'($urandom), DW'($urandom),
                     logic'($urandom_range(99) >= p_wr), logic'($urandom_range(31) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
